// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: triggered circular-buffer capture sequencer for a two-channel ADC (optional decimation via ADC_ACQ_DECIM_EN)
module adc_acq_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 14
) (
  input  logic                    adc_clk,
  input  logic                    adc_rst_i,
  input  logic [DATA_WIDTH-1:0]   adc_dat_a_i,
  input  logic [DATA_WIDTH-1:0]   adc_dat_b_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    force_trig_i,
  input  logic [DATA_WIDTH-1:0]   trig_level_i,
  input  logic [ADDR_WIDTH-1:0]   pre_i,
  input  logic [ADDR_WIDTH-1:0]   post_i,
`ifdef ADC_ACQ_DECIM_EN
  input  logic [15:0]             dec_i,
`endif
  output logic                    bram_we_o,
  output logic [ADDR_WIDTH-1:0]   bram_addr_o,
  output logic [2*DATA_WIDTH-1:0] bram_wdata_o,
  output logic [ADDR_WIDTH-1:0]   trig_addr_o,
  output logic                    busy_o,
  output logic                    done_o
);
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ARMED, S_POST} state_t;
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0]   r_pre;
  logic [ADDR_WIDTH-1:0]   r_post;
  logic [DATA_WIDTH-1:0]   r_prev_a;
  logic                    r_prev_v;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2*DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0]   r_trig;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_acc;
  logic                    w_trig;
  logic [ADDR_WIDTH-1:0]   w_cnt_nx;
  logic [ADDR_WIDTH-1:0]   w_post_eff;
`ifdef ADC_ACQ_DECIM_EN
  logic [15:0]             r_psc;
  logic [15:0]             w_psc_nx;
  assign w_psc_nx = (r_psc + 16'd1 >= dec_i) ? '0 : r_psc + 16'd1;
  assign w_acc    = (r_psc == '0);
`else
  assign w_acc    = 1'b1;
`endif
  assign w_trig     = force_trig_i | (r_prev_v && ($signed(r_prev_a) < $signed(trig_level_i))
                                               && ($signed(adc_dat_a_i) >= $signed(trig_level_i)));
  assign w_cnt_nx   = r_cnt + ADDR_WIDTH'(1);
  assign w_post_eff = (post_i == '0) ? ADDR_WIDTH'(1) : post_i;
  // capture FSM: writes accepted samples, counts pre/post, detects the trigger, drives registered outputs
  always_ff @(posedge adc_clk) begin
    r_we <= 1'b0;
    if (adc_rst_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_pre    <= '0;
      r_post   <= '0;
      r_prev_a <= '0;
      r_prev_v <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_trig   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef ADC_ACQ_DECIM_EN
      r_psc    <= '0;
`endif
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start_i) begin
        r_pre    <= pre_i;
        r_post   <= w_post_eff;
        r_ptr    <= '0;
        r_cnt    <= '0;
        r_prev_v <= 1'b0;
        r_done   <= 1'b0;
        r_busy   <= 1'b1;
        r_state  <= (pre_i == '0) ? S_ARMED : S_PRE;
`ifdef ADC_ACQ_DECIM_EN
        r_psc    <= '0;
`endif
      end
    end else begin
`ifdef ADC_ACQ_DECIM_EN
      r_psc <= w_psc_nx;
`endif
      if (w_acc) begin
        r_we     <= 1'b1;
        r_addr   <= r_ptr;
        r_wdata  <= {adc_dat_b_i, adc_dat_a_i};
        r_ptr    <= r_ptr + ADDR_WIDTH'(1);
        r_prev_a <= adc_dat_a_i;
        r_prev_v <= 1'b1;
        case (r_state)
          S_PRE: begin
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == r_pre) r_state <= S_ARMED;
          end
          S_ARMED: begin
            if (w_trig) begin
              r_trig <= r_ptr;
              r_cnt  <= ADDR_WIDTH'(1);
              if (r_post == ADDR_WIDTH'(1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else r_state <= S_POST;
            end
          end
          default: begin
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == r_post) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end
  assign bram_we_o    = r_we;
  assign bram_addr_o  = r_addr;
  assign bram_wdata_o = r_wdata;
  assign trig_addr_o  = r_trig;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
endmodule
